cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Memory-side responder for the cache_control protocol. It accepts instruction-read requests (iREN/iaddr) from the icache and data read/write requests from the dcache.
- It arbitrates between the two, serializes them onto the single RAM port using the ramstate handshake, and returns iwait/iload and dwait/dload.
- Sits between the caches and RAM. Single CPU.

Parameters:
- MAX_WAIT, 64, cycles a serving state may last without ramstate==ACCESS before timeout completion.
- FAULT_WORD, 32'hBAD1BAD1, load value returned on timeout.
- CNT_W, 16, width of the served-request counters.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- iREN  input  1  icache read request
- iaddr  input  32  icache word address
- iwait  output  1  0 only in the icache completion cycle
- iload  output  32  instruction word, valid when iwait==0
- dREN  input  1  dcache read request
- dWEN  input  1  dcache write request (dREN&dWEN treated as write)
- daddr  input  32  dcache address
- dstore  input  32  write data
- dwait  output  1  0 only in the dcache completion cycle
- dload  output  32  read data, valid when dwait==0
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- mem_fault  output  1  sticky, set on any timeout
- icount  output  CNT_W  completed icache requests, wraps
- dcount  output  CNT_W  completed dcache requests, wraps

Behaviour:
- Reset values: state IDLE, iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, mem_fault=0, icount=0, dcount=0, timeout counter=0, fairness flag=0.
- FSM states: IDLE, ISERV, DSERV.
- IDLE:
  - Selection: dcache wins when (dREN|dWEN) and fairness flag==0. Otherwise iREN selects the icache. Otherwise any d request selects the dcache.
  - Transition: icache selected -> ISERV; dcache selected -> DSERV.
  - Latching: the selected address, dstore and op (read/write) are registered on the transition edge.
  - No RAM strobes in IDLE.
- ISERV/DSERV:
  - RAM drive: ramREN/ramWEN, ramaddr and ramstore come from the latched registers, so the first RAM strobe appears 1 cycle after the request.
  - Timeout counter: increments every cycle in the state.
- Completion (ramstate==ACCESS):
  - In that same cycle the served wait drops to 0. Its load output is driven combinationally from ramload; writes drive 0 on dload.
  - The served count increments. The next state is IDLE.
  - Fairness flag is set to 1 after a DSERV completion and to 0 after an ISERV completion.
  - Minimum request-to-completion: 2 cycles.
- ramstate==ERROR: deassert RAM strobes for that cycle, then reissue the same request (retry). The timeout counter keeps running.
- Timeout:
  - Trigger: the counter reaches MAX_WAIT-1 without ACCESS.
  - Effect: complete as normal, with the load value FAULT_WORD. mem_fault is set until reset, and the count still increments.
- Abort: if the served request drops mid-service (iREN=0 in ISERV, or dREN|dWEN=0 in DSERV), return to IDLE next cycle. No completion, no count, strobes low from the abort edge.
- The served port must hold its address stable; a changed address mid-service is not re-latched.
- The unserved port sees wait=1 for the whole service.
- Outside completion cycles, iload and dload hold their last completed value.
- Reset mid-service: returns immediately to reset values; the RAM strobe drops asynchronously.
- Counters wrap from 2^CNT_W-1 to 0.

Test Plan:
- Single ifetch: iREN=1, iaddr=0x40, ramstate=ACCESS with ramload=0x8C220004 on the 2nd serving cycle → ramREN=1/ramaddr=0x40 from cycle 1. iwait=0 and iload=0x8C220004 in exactly one cycle; icount=1.
- Simultaneous request: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF), ACCESS after 1 cycle each.
  - The write is served first: ramWEN=1, ramstore=0xDEADBEEF.
  - The icache is served next even though dREN is reasserted.
  - dcount=1, icount=1.
- ERROR retry: DSERV read, ramstate ERROR for 1 cycle then ACCESS (ramload=0x12345678) → ramREN low for one cycle then reasserted; dload=0x12345678; mem_fault=0.
- Timeout: MAX_WAIT=8, ramstate held BUSY → on the 8th serving cycle iwait=0, iload=0xBAD1BAD1, mem_fault=1 and stays 1 through later good accesses.
- Abort: iREN dropped on the 2nd ISERV cycle → next cycle IDLE; ramREN=0; iwait never 0; icount unchanged.
- Reset mid-DSERV: nRST asserted asynchronously → ramWEN=0 immediately; all outputs at reset values; a new request after release completes normally.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache/RAM handshake bundle for cache_mem_arbiter
//
// Purpose : groups the icache, dcache and RAM port signals seen by the arbiter.
// Ports   : icache  iREN, iaddr -> iwait, iload
//           dcache  dREN, dWEN, daddr, dstore -> dwait, dload
//           RAM     ramREN, ramWEN, ramaddr, ramstore -> ramload, ramstate
// Modports: slave  = arbiter side, master = cache/RAM side (bench).

interface cache_mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - arbitrates icache/dcache requests onto one RAM port
//
// Purpose : serves one cache request at a time on the RAM port, returning
//           iwait/iload or dwait/dload in the completion cycle.
// Ports   : CLK, nRST (async, active-low)
//           bus       cache_mem_arbiter_if.slave (cache and RAM handshakes)
//           mem_fault sticky timeout flag
//           icount    completed icache requests (wraps)
//           dcount    completed dcache requests (wraps)

module cache_mem_arbiter #(
    parameter int          MAX_WAIT   = 64,
    parameter logic [31:0] FAULT_WORD = 32'hBAD1BAD1,
    parameter int          CNT_W      = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    cache_mem_arbiter_if.slave   bus,
    output logic                 mem_fault,
    output logic [CNT_W-1:0]     icount,
    output logic [CNT_W-1:0]     dcount
);

    localparam int TW = $clog2(MAX_WAIT) + 1;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_t;

    state_t         state, next_state;
    logic [TW-1:0]  tcount;
    logic           fair;
    logic           fault_q;
    logic [31:0]    lat_addr;
    logic [31:0]    lat_store;
    logic           lat_wen;
    logic [31:0]    iload_q;
    logic [31:0]    dload_q;

    logic           d_req;
    logic           sel_i, sel_d;
    logic           i_done, d_done;
    logic           tmo;
    logic           ram_on;
    logic [31:0]    i_word, d_word;

    assign d_req = bus.dREN | bus.dWEN;

    always_comb begin
        next_state = state;
        sel_i      = 1'b0;
        sel_d      = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        tmo        = 1'b0;
        ram_on     = 1'b0;
        case (state)
            IDLE: begin
                // dcache has priority unless it was served last
                if (d_req && !fair) begin
                    sel_d      = 1'b1;
                    next_state = DSERV;
                end else if (bus.iREN) begin
                    sel_i      = 1'b1;
                    next_state = ISERV;
                end else if (d_req) begin
                    sel_d      = 1'b1;
                    next_state = DSERV;
                end
            end
            ISERV: begin
                if (!bus.iREN) begin
                    next_state = IDLE;
                end else begin
                    ram_on = (bus.ramstate != RS_ERROR);
                    if (bus.ramstate == RS_ACCESS || tcount == TW'(MAX_WAIT - 1)) begin
                        i_done     = 1'b1;
                        tmo        = (bus.ramstate != RS_ACCESS);
                        next_state = IDLE;
                    end
                end
            end
            DSERV: begin
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    ram_on = (bus.ramstate != RS_ERROR);
                    if (bus.ramstate == RS_ACCESS || tcount == TW'(MAX_WAIT - 1)) begin
                        d_done     = 1'b1;
                        tmo        = (bus.ramstate != RS_ACCESS);
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Strobes are gated by the live request so an abort or reset drops them at once.
    assign bus.ramREN   = ram_on && !(state == DSERV && lat_wen);
    assign bus.ramWEN   = ram_on &&  (state == DSERV && lat_wen);
    assign bus.ramaddr  = lat_addr;
    assign bus.ramstore = lat_store;

    assign i_word = tmo ? FAULT_WORD : bus.ramload;
    assign d_word = tmo ? FAULT_WORD : (lat_wen ? 32'd0 : bus.ramload);

    assign bus.iwait = !i_done;
    assign bus.dwait = !d_done;
    assign bus.iload = i_done ? i_word : iload_q;
    assign bus.dload = d_done ? d_word : dload_q;

    assign mem_fault = fault_q | tmo;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            tcount    <= '0;
            fair      <= 1'b0;
            fault_q   <= 1'b0;
            lat_addr  <= '0;
            lat_store <= '0;
            lat_wen   <= 1'b0;
            iload_q   <= '0;
            dload_q   <= '0;
            icount    <= '0;
            dcount    <= '0;
        end else begin
            state <= next_state;

            if (state != IDLE && next_state != IDLE)
                tcount <= tcount + TW'(1);
            else
                tcount <= '0;

            if (sel_i) begin
                lat_addr <= bus.iaddr;
                lat_wen  <= 1'b0;
            end
            if (sel_d) begin
                lat_addr  <= bus.daddr;
                lat_store <= bus.dstore;
                lat_wen   <= bus.dWEN;
            end

            if (i_done) begin
                iload_q <= i_word;
                icount  <= icount + CNT_W'(1);
                fair    <= 1'b0;
            end
            if (d_done) begin
                dload_q <= d_word;
                dcount  <= dcount + CNT_W'(1);
                fair    <= 1'b1;
            end
            if (tmo)
                fault_q <= 1'b1;
        end
    end

endmodule
